// File: rtl/minimig_bank_sequencer.sv
// Runs one asynchronous-SRAM access per request for the bank selected by the bank mapper.
// Produces timed CE/OE/WE/byte strobes and returns read data with a single-cycle ack.
module minimig_bank_sequencer #(
  parameter int          SETUP_CYC     = 1,
  parameter int          ACCESS_CYC    = 2,
  parameter int          RECOVER_CYC   = 1,
  parameter logic [15:0] UNMAPPED_DATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  bank,
  input  logic [17:0] addr,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        bank_err,
  output logic [2:0]  ram_cs,
  output logic        ram_ce_n,
  output logic [17:0] ram_addr,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        ram_ub_n,
  output logic        ram_lb_n,
  output logic [15:0] ram_dout,
  output logic        ram_doe,
  input  logic [15:0] ram_din
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, RECOVER} state_t;

  localparam logic [2:0] SETUP_LD   = 3'(SETUP_CYC - 1);
  localparam logic [2:0] ACCESS_LD  = 3'(ACCESS_CYC - 1);
  localparam logic [2:0] RECOVER_LD = (RECOVER_CYC == 0) ? 3'd0 : 3'(RECOVER_CYC - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        we_q, we_q_nxt;
  logic        uds_q, uds_q_nxt;
  logic        lds_q, lds_q_nxt;

  logic        ack_nxt;
  logic [15:0] rdata_nxt;
  logic        bank_err_nxt;
  logic [2:0]  ram_cs_nxt;
  logic        ram_ce_n_nxt;
  logic [17:0] ram_addr_nxt;
  logic        ram_oe_n_nxt;
  logic        ram_we_n_nxt;
  logic        ram_ub_n_nxt;
  logic        ram_lb_n_nxt;
  logic [15:0] ram_dout_nxt;
  logic        ram_doe_nxt;

  logic        multi_bank;
  logic [2:0]  bank_index;

  // Ascending scan so the highest set bit overwrites lower ones.
  function automatic logic [2:0] encode_bank(input logic [7:0] b);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign bank_index = encode_bank(bank);
  assign multi_bank = (bank & (bank - 8'd1)) != 8'd0;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    we_q_nxt     = we_q;
    uds_q_nxt    = uds_q;
    lds_q_nxt    = lds_q;
    ack_nxt      = 1'b0;
    rdata_nxt    = rdata;
    bank_err_nxt = bank_err;
    ram_cs_nxt   = ram_cs;
    ram_ce_n_nxt = ram_ce_n;
    ram_addr_nxt = ram_addr;
    ram_oe_n_nxt = ram_oe_n;
    ram_we_n_nxt = ram_we_n;
    ram_ub_n_nxt = ram_ub_n;
    ram_lb_n_nxt = ram_lb_n;
    ram_dout_nxt = ram_dout;
    ram_doe_nxt  = ram_doe;

    case (state)
      IDLE: begin
        if (req) begin
          we_q_nxt  = we;
          uds_q_nxt = uds_n;
          lds_q_nxt = lds_n;
          if (multi_bank) bank_err_nxt = 1'b1;
          if (bank == 8'd0) begin
            // Unmapped: no pin activity, reads see the fill pattern, writes vanish.
            if (!we) rdata_nxt = UNMAPPED_DATA;
            state_nxt = DONE;
          end else begin
            ram_ce_n_nxt = 1'b0;
            ram_cs_nxt   = bank_index;
            ram_addr_nxt = addr;
            if (we) ram_dout_nxt = wdata;
            ram_doe_nxt  = we;
            cnt_nxt      = SETUP_LD;
            state_nxt    = SETUP;
          end
        end
      end
      SETUP: begin
        if (cnt == 3'd0) begin
          ram_oe_n_nxt = we_q;
          ram_we_n_nxt = !we_q;
          ram_ub_n_nxt = uds_q;
          ram_lb_n_nxt = lds_q;
          cnt_nxt      = ACCESS_LD;
          state_nxt    = ACCESS;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      ACCESS: begin
        if (cnt == 3'd0) begin
          if (!we_q) rdata_nxt = ram_din;
          ram_oe_n_nxt = 1'b1;
          ram_we_n_nxt = 1'b1;
          ram_ub_n_nxt = 1'b1;
          ram_lb_n_nxt = 1'b1;
          state_nxt    = DONE;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      DONE: begin
        // CE and the data driver are released here, one clock after WE rises.
        ack_nxt      = 1'b1;
        ram_ce_n_nxt = 1'b1;
        ram_doe_nxt  = 1'b0;
        cnt_nxt      = RECOVER_LD;
        state_nxt    = (RECOVER_CYC == 0) ? IDLE : RECOVER;
      end
      RECOVER: begin
        if (cnt == 3'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 3'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      we_q     <= 1'b0;
      uds_q    <= 1'b1;
      lds_q    <= 1'b1;
      ack      <= 1'b0;
      rdata    <= 16'd0;
      bank_err <= 1'b0;
      ram_cs   <= 3'd0;
      ram_ce_n <= 1'b1;
      ram_addr <= 18'd0;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
      ram_ub_n <= 1'b1;
      ram_lb_n <= 1'b1;
      ram_dout <= 16'd0;
      ram_doe  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      we_q     <= we_q_nxt;
      uds_q    <= uds_q_nxt;
      lds_q    <= lds_q_nxt;
      ack      <= ack_nxt;
      rdata    <= rdata_nxt;
      bank_err <= bank_err_nxt;
      ram_cs   <= ram_cs_nxt;
      ram_ce_n <= ram_ce_n_nxt;
      ram_addr <= ram_addr_nxt;
      ram_oe_n <= ram_oe_n_nxt;
      ram_we_n <= ram_we_n_nxt;
      ram_ub_n <= ram_ub_n_nxt;
      ram_lb_n <= ram_lb_n_nxt;
      ram_dout <= ram_dout_nxt;
      ram_doe  <= ram_doe_nxt;
    end
  end

endmodule

// File: tb/tb_minimig_bank_sequencer.sv
// Directed bench for minimig_bank_sequencer: a default instance plus one with a longer recovery gap.
// Expected values are hand-derived cycle counts and data patterns.
module tb_minimig_bank_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, we, uds_n, lds_n;
  logic [7:0]  bank;
  logic [17:0] addr;
  logic [15:0] wdata, ram_din;

  logic        ack, bank_err, ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n, ram_doe;
  logic [15:0] rdata, ram_dout;
  logic [2:0]  ram_cs;
  logic [17:0] ram_addr;

  logic        ack_r2, bank_err_r2, ram_ce_n_r2, ram_oe_n_r2, ram_we_n_r2, ram_ub_n_r2, ram_lb_n_r2, ram_doe_r2;
  logic [15:0] rdata_r2, ram_dout_r2;
  logic [2:0]  ram_cs_r2;
  logic [17:0] ram_addr_r2;

  int n_checks = 0;
  int n_fail   = 0;

  int ack_tick, n_oe, n_we, n_ce, n_ub, n_lb, n_doe;
  logic [2:0]  cs_first;
  logic [17:0] addr_first;
  logic [15:0] dout_at_we;

  always #5 clk = ~clk;

  minimig_bank_sequencer dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .bank(bank), .addr(addr),
    .uds_n(uds_n), .lds_n(lds_n), .wdata(wdata), .ack(ack), .rdata(rdata),
    .bank_err(bank_err), .ram_cs(ram_cs), .ram_ce_n(ram_ce_n), .ram_addr(ram_addr),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_ub_n(ram_ub_n), .ram_lb_n(ram_lb_n),
    .ram_dout(ram_dout), .ram_doe(ram_doe), .ram_din(ram_din)
  );

  minimig_bank_sequencer #(.RECOVER_CYC(2)) dut_r2 (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .bank(bank), .addr(addr),
    .uds_n(uds_n), .lds_n(lds_n), .wdata(wdata), .ack(ack_r2), .rdata(rdata_r2),
    .bank_err(bank_err_r2), .ram_cs(ram_cs_r2), .ram_ce_n(ram_ce_n_r2), .ram_addr(ram_addr_r2),
    .ram_oe_n(ram_oe_n_r2), .ram_we_n(ram_we_n_r2), .ram_ub_n(ram_ub_n_r2), .ram_lb_n(ram_lb_n_r2),
    .ram_dout(ram_dout_r2), .ram_doe(ram_doe_r2), .ram_din(ram_din)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [7:0] b,
                               input logic [17:0] a, input logic u, input logic l,
                               input logic [15:0] wd);
    req   = r;
    we    = w;
    bank  = b;
    addr  = a;
    uds_n = u;
    lds_n = l;
    wdata = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Tick t=0 is the edge that samples req; ack_tick stays -1 if ack never arrives.
  task automatic watchAccess(input int budget);
    ack_tick = -1;
    n_oe = 0; n_we = 0; n_ce = 0; n_ub = 0; n_lb = 0; n_doe = 0;
    dout_at_we = 16'h0;
    for (int t = 0; t < budget; t++) begin
      tick();
      if (t == 0) begin
        req        = 1'b0;
        cs_first   = ram_cs;
        addr_first = ram_addr;
      end
      if (!ram_oe_n) n_oe++;
      if (!ram_ce_n) n_ce++;
      if (!ram_ub_n) n_ub++;
      if (!ram_lb_n) n_lb++;
      if (ram_doe)   n_doe++;
      if (!ram_we_n) begin
        n_we++;
        dout_at_we = ram_dout;
      end
      if (ack) begin
        ack_tick = t;
        break;
      end
    end
  endtask

  initial begin
    int ack_t[3];
    int ack_t2[3];
    int n_a, n_a2, run, min_run, n_bad;

    reset_n = 1'b0;
    ram_din = 16'hBEEF;
    applyStimulus(1'b0, 1'b0, 8'h00, 18'h0, 1'b1, 1'b1, 16'h0);
    repeat (3) tick();

    checkOutput("rst_ack", ack, 1'b0);
    checkOutput("rst_ce_n", ram_ce_n, 1'b1);
    checkOutput("rst_strobes", {ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n}, 4'hF);
    checkOutput("rst_doe", ram_doe, 1'b0);
    checkOutput("rst_data", {rdata, ram_dout}, 32'h0);
    checkOutput("rst_addr_cs", {ram_addr, ram_cs}, 21'h0);
    checkOutput("rst_bank_err", bank_err, 1'b0);
    reset_n = 1'b1;
    repeat (2) tick();

    $display("[TB] mapped read, bank 0");
    applyStimulus(1'b1, 1'b0, 8'h01, 18'h12345, 1'b0, 1'b0, 16'h0);
    watchAccess(20);
    checkOutput("rd_ack_tick", 32'(ack_tick), 32'd4);
    checkOutput("rd_oe_low", 32'(n_oe), 32'd2);
    checkOutput("rd_we_low", 32'(n_we), 32'd0);
    checkOutput("rd_ce_low", 32'(n_ce), 32'd4);
    checkOutput("rd_cs", cs_first, 3'd0);
    checkOutput("rd_addr", addr_first, 18'h12345);
    checkOutput("rd_rdata", rdata, 16'hBEEF);
    tick();
    checkOutput("rd_ack_pulse", ack, 1'b0);
    checkOutput("rd_rdata_hold", rdata, 16'hBEEF);
    repeat (3) tick();

    $display("[TB] mapped write, bank 7, upper byte");
    applyStimulus(1'b1, 1'b1, 8'h80, 18'h00ABC, 1'b0, 1'b1, 16'hA55A);
    watchAccess(20);
    checkOutput("wr_ack_tick", 32'(ack_tick), 32'd4);
    checkOutput("wr_cs", cs_first, 3'd7);
    checkOutput("wr_we_low", 32'(n_we), 32'd2);
    checkOutput("wr_oe_low", 32'(n_oe), 32'd0);
    checkOutput("wr_ub_low", 32'(n_ub), 32'd2);
    checkOutput("wr_lb_low", 32'(n_lb), 32'd0);
    checkOutput("wr_doe_high", 32'(n_doe), 32'd4);
    checkOutput("wr_dout", dout_at_we, 16'hA55A);
    checkOutput("wr_rdata_kept", rdata, 16'hBEEF);
    repeat (3) tick();

    $display("[TB] unmapped read");
    applyStimulus(1'b1, 1'b0, 8'h00, 18'h00777, 1'b0, 1'b0, 16'h0);
    watchAccess(20);
    checkOutput("um_ack_tick", 32'(ack_tick), 32'd1);
    checkOutput("um_ce_low", 32'(n_ce), 32'd0);
    checkOutput("um_oe_low", 32'(n_oe), 32'd0);
    checkOutput("um_rdata", rdata, 16'hFFFF);
    checkOutput("um_bank_err", bank_err, 1'b0);
    repeat (3) tick();

    $display("[TB] multi-bit bank select");
    applyStimulus(1'b1, 1'b0, 8'h14, 18'h00001, 1'b0, 1'b0, 16'h0);
    watchAccess(20);
    checkOutput("mb_cs", cs_first, 3'd4);
    checkOutput("mb_bank_err", bank_err, 1'b1);
    checkOutput("mb_ack_tick", 32'(ack_tick), 32'd4);
    for (int i = 0; i < 3; i++) begin
      repeat (3) tick();
      applyStimulus(1'b1, 1'b0, 8'h01, 18'(i), 1'b0, 1'b0, 16'h0);
      watchAccess(20);
    end
    checkOutput("mb_bank_err_sticky", bank_err, 1'b1);
    repeat (3) tick();

    $display("[TB] back-to-back reads with req held");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    ack_t  = '{-100, -100, -100};
    ack_t2 = '{-100, -100, -100};
    n_a = 0; n_a2 = 0; run = 0; min_run = 99;
    applyStimulus(1'b1, 1'b0, 8'h01, 18'h00200, 1'b0, 1'b0, 16'h0);
    for (int t = 0; t < 60; t++) begin
      tick();
      if (ack_r2 && n_a2 < 3) begin
        ack_t2[n_a2] = t;
        n_a2++;
      end
      if (ack && n_a < 3) begin
        ack_t[n_a] = t;
        n_a++;
      end
      if (ram_ce_n_r2) run++;
      else begin
        if (n_a2 > 0 && run > 0 && run < min_run) min_run = run;
        run = 0;
      end
      if (n_a2 == 3 && n_a == 3) break;
    end
    req = 1'b0;
    checkOutput("b2b_r2_first", 32'(ack_t2[0]), 32'd4);
    checkOutput("b2b_r2_gap1", 32'(ack_t2[1] - ack_t2[0]), 32'd7);
    checkOutput("b2b_r2_gap2", 32'(ack_t2[2] - ack_t2[1]), 32'd7);
    checkOutput("b2b_r2_ce_high", 32'(min_run), 32'd3);
    checkOutput("b2b_dflt_gap1", 32'(ack_t[1] - ack_t[0]), 32'd6);
    checkOutput("b2b_dflt_gap2", 32'(ack_t[2] - ack_t[1]), 32'd6);
    repeat (10) tick();

    $display("[TB] reset during write access");
    applyStimulus(1'b1, 1'b1, 8'h01, 18'h3FFFF, 1'b0, 1'b0, 16'h1234);
    tick();
    req = 1'b0;
    tick();
    checkOutput("ar_pre_we", ram_we_n, 1'b0);
    checkOutput("ar_pre_ce_doe", {ram_ce_n, ram_doe}, 2'b01);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_we", ram_we_n, 1'b1);
    checkOutput("ar_ce", ram_ce_n, 1'b1);
    checkOutput("ar_doe", ram_doe, 1'b0);
    #1;
    reset_n = 1'b1;
    n_bad = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (ack || !ram_ce_n) n_bad++;
    end
    checkOutput("ar_quiet", 32'(n_bad), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h02, 18'h00042, 1'b0, 1'b0, 16'h0);
    watchAccess(20);
    checkOutput("ar_next_ack_tick", 32'(ack_tick), 32'd4);
    checkOutput("ar_next_cs", cs_first, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
